// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed hex display scanner with frame-coherent input snapshot and per-digit anti-ghost blanking.
// Outputs are registered and lag the scan counters by one clk; data/Display_Flag are only sampled at frame loads.
module seg_scan_display #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 2000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        Display_Flag,
    output logic [2:0]  which,
    output logic [7:0]  seg
);

    localparam int              DIV_W     = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [7:0]      SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_data_q, shadow_data_d;
    logic             shadow_blank_q, shadow_blank_d;
    logic             load_pending_q, load_pending_d;
    logic [2:0]       which_q, which_d;
    logic [7:0]       seg_q, seg_d;

    logic             div_end;
    logic             load;
    logic [3:0]       nibble;
    logic [7:0]       lit;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    always_comb begin
        div_end = (div_q == DIV_LAST);
        div_d   = div_end ? '0 : div_q + DIV_W'(1);
        idx_d   = div_end ? idx_q + 3'd1 : idx_q;

        // Snapshot only at the end of digit 7 (or right after reset) so a frame never mixes two values.
        load           = load_pending_q | (div_end & (idx_q == 3'd7));
        shadow_data_d  = load ? data : shadow_data_q;
        shadow_blank_d = load ? Display_Flag : shadow_blank_q;
        load_pending_d = load ? 1'b0 : load_pending_q;

        nibble  = shadow_data_q[{idx_q, 2'b00} +: 4];
        lit     = {1'b0, enc(nibble)};
        which_d = idx_q;
        if (shadow_blank_q || (div_q < BLANK_END))
            seg_d = SEG_OFF;
        else
            seg_d = SEG_ACTIVE_LOW ? ~lit : lit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q          <= '0;
            idx_q          <= 3'd0;
            shadow_data_q  <= 32'd0;
            shadow_blank_q <= 1'b1;
            load_pending_q <= 1'b1;
            which_q        <= 3'd0;
            seg_q          <= SEG_OFF;
        end else begin
            div_q          <= div_d;
            idx_q          <= idx_d;
            shadow_data_q  <= shadow_data_d;
            shadow_blank_q <= shadow_blank_d;
            load_pending_q <= load_pending_d;
            which_q        <= which_d;
            seg_q          <= seg_d;
        end
    end

    assign which = which_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=4, BLANK_CYC=1; a second instance covers active-high segments.
module tb_seg_scan_display;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        Display_Flag;
    logic [2:0]  which;
    logic [7:0]  seg;
    logic [2:0]  which_hi;
    logic [7:0]  seg_hi;

    int checks = 0;
    int passed = 0;

    // Active-low patterns for 0x12345678, digit 0..7 = '8','7','6','5','4','3','2','1'
    logic [7:0] code_a [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    seg_scan_display #(.SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b1)) u_dut (
        .clk(clk), .rst(rst), .data(data), .Display_Flag(Display_Flag),
        .which(which), .seg(seg)
    );

    seg_scan_display #(.SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst(rst), .data(data), .Display_Flag(Display_Flag),
        .which(which_hi), .seg(seg_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data = 32'd0;
        Display_Flag = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (which !== 3'd0 || seg !== 8'hFF)
            $display("FAIL reset_async which=%0d seg=%h need 0/ff", which, seg);
        else passed++;
        checks++;
        if (which_hi !== 3'd0 || seg_hi !== 8'h00)
            $display("FAIL reset_async_hi which=%0d seg=%h need 0/00", which_hi, seg_hi);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (which !== 3'd0 || seg !== 8'hFF)
                $display("FAIL reset_hold cyc=%0d which=%0d seg=%h need 0/ff", i, which, seg);
            else passed++;
        end
    endtask

    task automatic test_normal_scan();
        int p;
        logic [7:0] exp_s;
        data = 32'h12345678;
        Display_Flag = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            p = i % 32;
            exp_s = (p % 4 == 0) ? 8'hFF : code_a[p / 4];
            checks++;
            if (which !== 3'(p / 4) || seg !== exp_s)
                $display("FAIL normal_scan i=%0d which=%0d seg=%h need %0d/%h", i, which, seg, p / 4, exp_s);
            else passed++;
        end
    endtask

    task automatic test_frame_update();
        int p;
        logic [7:0] exp_s;
        for (int i = 0; i < 64; i++) begin
            tick();
            p = i % 32;
            exp_s = (p % 4 == 0) ? 8'hFF : ((i < 32) ? code_a[p / 4] : 8'h8E);
            checks++;
            if (which !== 3'(p / 4) || seg !== exp_s)
                $display("FAIL frame_update i=%0d which=%0d seg=%h need %0d/%h", i, which, seg, p / 4, exp_s);
            else passed++;
            if (i == 12) data = 32'hFFFFFFFF;
        end
    endtask

    task automatic test_blanking();
        int p;
        logic [7:0] exp_s;
        for (int i = 0; i < 96; i++) begin
            tick();
            p = i % 32;
            if (i >= 32 && i < 64)
                exp_s = 8'hFF;
            else
                exp_s = (p % 4 == 0) ? 8'hFF : 8'h8E;
            checks++;
            if (which !== 3'(p / 4) || seg !== exp_s)
                $display("FAIL blanking i=%0d which=%0d seg=%h need %0d/%h", i, which, seg, p / 4, exp_s);
            else passed++;
            if (i == 10) Display_Flag = 1'b1;
            // Cleared just before the end-of-frame load edge: that edge must capture 0.
            if (i == 62) Display_Flag = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int p;
        logic [7:0] exp_s;
        for (int i = 0; i < 22; i++) tick();
        checks++;
        if (which !== 3'd5 || seg !== 8'h8E)
            $display("FAIL pre_reset_lit which=%0d seg=%h need 5/8e", which, seg);
        else passed++;
        data = 32'h12345678;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (which !== 3'd0 || seg !== 8'hFF)
            $display("FAIL reset_mid_async which=%0d seg=%h need 0/ff", which, seg);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (which !== 3'd0 || seg !== 8'hFF)
                $display("FAIL reset_mid_hold cyc=%0d which=%0d seg=%h need 0/ff", i, which, seg);
            else passed++;
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            p = i;
            exp_s = (p % 4 == 0) ? 8'hFF : code_a[p / 4];
            checks++;
            if (which !== 3'(p / 4) || seg !== exp_s)
                $display("FAIL reset_restart i=%0d which=%0d seg=%h need %0d/%h", i, which, seg, p / 4, exp_s);
            else passed++;
        end
    endtask

    task automatic test_polarity();
        logic [7:0] exp_s;
        data = 32'h0000000A;
        Display_Flag = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int p = 0; p < 32; p++) begin
            tick();
            if (p % 4 == 0)  exp_s = 8'h00;
            else if (p < 4)  exp_s = 8'h77;
            else             exp_s = 8'h3F;
            checks++;
            if (which_hi !== 3'(p / 4) || seg_hi !== exp_s)
                $display("FAIL polarity p=%0d which=%0d seg=%h need %0d/%h", p, which_hi, seg_hi, p / 4, exp_s);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_normal_scan();
        test_frame_update();
        test_blanking();
        test_reset_mid();
        test_polarity();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
